mem_add_seq: RTL
================

MEM_ADD_SEQ -- requirements
Module: mem_add_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a vector add; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, synchronous cancel of a running operation.
REQ-005 SHALL have port base_x, input, 4, first X-memory element address.
REQ-006 SHALL have port base_y, input, 4, first Y-memory element address.
REQ-007 SHALL have port length, input, 5, element count, 0..16; values >16 clamp to 16.
REQ-008 SHALL have port dst_sel, input, 1, destination: 0 = write sum into X, 1 = write sum into Y.
REQ-009 SHALL have port MemOverflow, input, 1, carry-out of the downstream 64-bit X+Y adder.
REQ-010 SHALL have ports read_addressX and read_addressY, output, 4 each, read addresses to the address/adder stage.
REQ-011 SHALL have ports write_addressX and write_addressY, output, 4 each, write addresses to the address/adder stage.
REQ-012 SHALL have ports write_X_enable and write_Y_enable, output, 1 each, write strobes; at most one high per cycle.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port ovf_count, output, 5, count of overflowed element writes in the last operation.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, WAIT, WRITE, DONE.
REQ-017 IDLE: on start, SHALL latch base_x, base_y, clamped length, and dst_sel; clear the index and ovf_count; go to READ, or to DONE if the clamped length is 0.
REQ-018 READ (1 cycle): SHALL drive read_addressX = base_x+idx and read_addressY = base_y+idx, both mod 16.
REQ-019 WAIT (1 cycle): SHALL hold the read addresses to cover the one-cycle synchronous memory read latency.
REQ-020 WRITE (1 cycle): SHALL drive write_addressX = base_x+idx and write_addressY = base_y+idx (mod 16), and assert write_X_enable if dst_sel=0 or write_Y_enable if dst_sel=1.
REQ-021 In WRITE, SHALL increment ovf_count (saturating at 16) when MemOverflow=1.
REQ-022 After WRITE, SHALL increment idx; if idx+1 equals the latched length, go to DONE, else go to READ.
REQ-023 Throughput SHALL be 3 cycles per element; an N-element operation SHALL take 3N cycles from the first READ to DONE.
REQ-024 DONE (1 cycle): SHALL assert done=1, then return to IDLE; busy SHALL be 1 in DONE.
REQ-025 Address arithmetic SHALL wrap modulo 16 (e.g. base 14, idx 3 -> address 1).
REQ-026 start while busy SHALL be ignored; latched parameters SHALL NOT change during an operation.
REQ-027 abort in READ or WAIT SHALL go to IDLE next cycle with no write strobe; abort in WRITE SHALL let that write complete, then go to IDLE; abort SHALL NOT produce a done pulse.
REQ-028 When start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 Outside WRITE, both write enables SHALL be 0 and the write addresses SHALL be driven to 0.
REQ-030 In IDLE and DONE, read addresses SHALL be 0.
REQ-031 ovf_count SHALL hold its value after DONE until the next accepted start.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, idx=0, all addresses 0, both write enables 0, busy=0, done=0, ovf_count=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation with no further write strobe and no done pulse.

Verification
REQ-034 base_x=0, base_y=0, length=4, dst_sel=0, MemOverflow=0 -> 4 write_X_enable pulses at addresses 0,1,2,3, 3 cycles apart; done 12 cycles after the first READ; ovf_count=0.
REQ-035 base_x=14, base_y=3, length=4, dst_sel=1 -> X read addresses 14,15,0,1; Y write addresses 3,4,5,6; only write_Y_enable pulses.
REQ-036 length=0 -> done one cycle after start with no strobes; length=20 -> exactly 16 writes.
REQ-037 MemOverflow=1 on the 2nd and 4th writes of length=5 -> ovf_count=2 after done.
REQ-038 abort in WAIT of element 2 -> exactly 1 write total, busy low next cycle, no done; start while busy -> ignored.
REQ-039 reset pulsed during WRITE -> write enable drops asynchronously; all outputs 0; a subsequent start runs normally.

Source files
------------

// File: rtl/mem_add_seq.sv
// mem_add_seq: sequencer for an element-wise vector add over two 16-entry
// memories (X and Y). Each element takes READ -> WAIT -> WRITE, so the
// downstream adder sees three cycles per element. The sum is written back
// into X or Y as selected at start. Writes with adder carry-out are counted.
module mem_add_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] base_x,
  input  logic [3:0] base_y,
  input  logic [4:0] length,
  input  logic       dst_sel,
  input  logic       MemOverflow,
  output logic [3:0] read_addressX,
  output logic [3:0] read_addressY,
  output logic [3:0] write_addressX,
  output logic [3:0] write_addressY,
  output logic       write_X_enable,
  output logic       write_Y_enable,
  output logic       busy,
  output logic       done,
  output logic [4:0] ovf_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [4:0] MAX_LEN = 5'd16;

  state_t     r_state;
  state_t     w_next_state;

  // Operation parameters captured when a start is accepted.
  logic [3:0] r_base_x;
  logic [3:0] r_base_y;
  logic [4:0] r_len;
  logic       r_dst_sel;

  // Element index and overflow counter.
  logic [3:0] r_idx;
  logic [4:0] r_ovf_count;

  logic [4:0] w_len_clamped;
  logic       w_accept;
  logic       w_last_elem;
  logic [3:0] w_addr_x;
  logic [3:0] w_addr_y;
  logic       w_ovf_inc;

  // Lengths beyond the memory depth would only revisit addresses; cap at 16.
  assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // Abort has priority over start, even while idle.
  assign w_accept = (r_state == IDLE) && start && !abort;

  // The element being written is the last one when idx+1 reaches the length.
  assign w_last_elem = (({1'b0, r_idx} + 5'd1) == r_len);

  // 4-bit adds wrap naturally modulo 16.
  assign w_addr_x = r_base_x + r_idx;
  assign w_addr_y = r_base_y + r_idx;

  // Count carry-out only on real write cycles, saturating at 16.
  assign w_ovf_inc = (r_state == WRITE) && MemOverflow && (r_ovf_count < MAX_LEN);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort in READ/WAIT leaves before any strobe, abort in
  // WRITE is acted on only after the strobe cycle has completed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (w_len_clamped == 5'd0) ? DONE : READ;
        end
      end
      READ: begin
        w_next_state = abort ? IDLE : WAIT;
      end
      WAIT: begin
        w_next_state = abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_last_elem) begin
          w_next_state = DONE;
        end else begin
          w_next_state = READ;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Capture operation parameters on an accepted start; hold them otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base_x  <= 4'd0;
      r_base_y  <= 4'd0;
      r_len     <= 5'd0;
      r_dst_sel <= 1'b0;
    end else if (w_accept) begin
      r_base_x  <= base_x;
      r_base_y  <= base_y;
      r_len     <= w_len_clamped;
      r_dst_sel <= dst_sel;
    end
  end

  // Element index: cleared on start, advanced after each write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 4'd0;
    end else if (w_accept) begin
      r_idx <= 4'd0;
    end else if (r_state == WRITE) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // Overflow counter: cleared on start, held after the operation ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_count <= 5'd0;
    end else if (w_accept) begin
      r_ovf_count <= 5'd0;
    end else if (w_ovf_inc) begin
      r_ovf_count <= r_ovf_count + 5'd1;
    end
  end

  // Outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    read_addressX  = 4'd0;
    read_addressY  = 4'd0;
    write_addressX = 4'd0;
    write_addressY = 4'd0;
    write_X_enable = 1'b0;
    write_Y_enable = 1'b0;
    case (r_state)
      READ, WAIT: begin
        read_addressX = w_addr_x;
        read_addressY = w_addr_y;
      end
      WRITE: begin
        read_addressX  = w_addr_x;
        read_addressY  = w_addr_y;
        write_addressX = w_addr_x;
        write_addressY = w_addr_y;
        write_X_enable = !r_dst_sel;
        write_Y_enable = r_dst_sel;
      end
      default: begin
      end
    endcase
  end

  // Status outputs.
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign ovf_count = r_ovf_count;

endmodule
